// File: rtl/ring_freq_meter.sv
// Ring-oscillator frequency meter: synchronises osc_in, counts its rising edges
// over a 2^(GATE_BASE_LOG2+gate_sel) cycle gate window and reports a saturating count.
module ring_freq_meter #(
  parameter int SYNC_STAGES    = 2,
  parameter int CNT_W          = 16,
  parameter int GATE_BASE_LOG2 = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             osc_in,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       gate_sel,
  output logic             busy,
  output logic             result_valid,
  output logic [CNT_W-1:0] result,
  output logic             overflow
);

  // Wide enough to hold the longest window, 2^(GATE_BASE_LOG2+7).
  localparam int GATE_W = GATE_BASE_LOG2 + 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_GATE = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [GATE_W-1:0] GATE_ONE = {{(GATE_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   hist_reg;
  logic                   edge_det;

  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic [GATE_W-1:0] gate_cnt_reg;
  logic [GATE_W-1:0] gate_load;
  logic [CNT_W-1:0]  edge_cnt_reg;
  logic              sat_reg;
  logic              busy_reg;
  logic              valid_reg;
  logic [CNT_W-1:0]  result_reg;
  logic              overflow_reg;

  // The synchroniser and edge history run in every state so the first GATE
  // cycle already sees a settled history bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      hist_reg <= 1'b0;
    end else begin
      if (SYNC_STAGES > 1) begin
        sync_reg <= {sync_reg[SYNC_STAGES-2:0], osc_in};
      end else begin
        sync_reg <= osc_in;
      end
      hist_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign edge_det  = sync_reg[SYNC_STAGES-1] & ~hist_reg;
  assign gate_load = GATE_ONE << (GATE_BASE_LOG2 + 32'(gate_sel));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (start) state_next = S_ARM;
      S_ARM:  state_next = abort ? S_IDLE : S_GATE;
      S_GATE: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (gate_cnt_reg == GATE_ONE) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      gate_cnt_reg <= '0;
      edge_cnt_reg <= '0;
      sat_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      result_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != S_IDLE);
      valid_reg <= (state_reg == S_DONE);
      case (state_reg)
        S_ARM: begin
          // Loading the window here is what freezes gate_sel for the run.
          gate_cnt_reg <= gate_load;
          edge_cnt_reg <= '0;
          sat_reg      <= 1'b0;
        end
        S_GATE: begin
          gate_cnt_reg <= gate_cnt_reg - GATE_ONE;
          if (edge_det) begin
            if (edge_cnt_reg == CNT_MAX) begin
              sat_reg <= 1'b1;
            end else begin
              edge_cnt_reg <= edge_cnt_reg + 1'b1;
            end
          end
        end
        S_DONE: begin
          result_reg   <= edge_cnt_reg;
          overflow_reg <= sat_reg;
        end
        default: ;
      endcase
    end
  end

  assign busy         = busy_reg;
  assign result_valid = valid_reg;
  assign result       = result_reg;
  assign overflow     = overflow_reg;

endmodule

// File: doc/ring_freq_meter.md
Name: ring_freq_meter

Overview:
Measures the frequency of a free-running ring-oscillator output in the system clock domain. The oscillator net is asynchronous to clk. The block synchronises it, counts its rising edges over a programmable gate window of clk cycles, and reports a saturating count with valid and overflow flags. It sits beside the oscillator/tap-select logic and gives the design an on-chip readout, so the oscillator no longer has to be probed externally.

Parameters:
SYNC_STAGES, 2, number of flops in the osc_in synchroniser (minimum 2)
CNT_W, 16, width of the edge counter and result
GATE_BASE_LOG2, 6, log2 of the shortest gate window; window = 2^(GATE_BASE_LOG2+gate_sel) clk cycles

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
osc_in  input  1  oscillator signal, asynchronous to clk
start  input  1  request a measurement; sampled only in IDLE
abort  input  1  cancel an in-progress measurement
gate_sel  input  3  gate window select, 0..7 gives 64..8192 cycles at default parameters
busy  output  1  high from ARM through DONE
result_valid  output  1  one-cycle pulse when result updates
result  output  CNT_W  last completed edge count
overflow  output  1  last completed count saturated

Behaviour:
- Reset: rst_n is asynchronous and active-low. All of the following clear to 0: state=IDLE, synchroniser, edge-history flop, counters, busy, result_valid, result, overflow.
- Synchroniser: SYNC_STAGES-flop chain, followed by one history flop.
  - edge = sync_out & ~hist.
  - Runs in every state.
  - Inputs faster than clk/2 alias; callers must prescale. This is not detected.
- FSM states: IDLE, ARM, GATE, DONE.
  - IDLE:
    - busy=0.
    - start=1 at an edge → ARM.
    - start is level-sampled; holding it high re-triggers after DONE.
  - ARM (1 cycle):
    - edge counter cleared.
    - gate_sel latched; gate_sel changes after this point are ignored.
    - gate down-counter loaded with N = 2^(GATE_BASE_LOG2+gsel).
    - → GATE.
  - GATE:
    - Exactly N cycles.
    - In each cycle, edge=1 increments the counter. The counter saturates at 2^CNT_W−1 and sets an internal sat flag.
    - Gate counter decrements; GATE → DONE on the cycle it reaches 1.
  - DONE (1 cycle):
    - result ← count, overflow ← sat.
    - result_valid=1.
    - → IDLE.
- Latency: start sampled at edge t gives result_valid high during the cycle following edge t+N+2.
- busy is registered and equals (state != IDLE).
- abort:
  - abort=1 in ARM or GATE → IDLE next edge.
  - No result_valid is issued; result and overflow keep their previous values.
  - abort in DONE is ignored: the result completes.
  - abort has priority over gate expiry.
- start while busy is ignored. There is no queuing.
- result and overflow hold until the next DONE.
- An edge in the final GATE cycle is counted. An edge seen in ARM or DONE is not counted.
- Asserting rst_n low mid-measurement drops to IDLE immediately and clears all outputs.

Test Plan:
- Reset → busy=0, result_valid=0, result=0, overflow=0. Then start=1 for 1 cycle with osc_in held 0 and gate_sel=0 → result_valid pulse at cycle t+66, result=0, overflow=0.
- osc_in square wave, period 8 clk, gate_sel=0 (64-cycle window) → result=8, overflow=0, busy high for exactly 66 cycles.
- osc_in period 4 clk, gate_sel=7 (8192-cycle window) → result=2048.
- CNT_W=8, osc_in period 4, gate_sel=4 (1024-cycle window, 256 edges) → result=255, overflow=1. Then rerun with gate_sel=0 → result=16, overflow=0.
- Complete one measurement (result=8). Start a second, pulse start again mid-GATE, then abort=1 at GATE cycle 20 → state returns to IDLE, no result_valid, result stays 8. A start issued after that is accepted normally.
- Assert rst_n low during GATE → busy, result, and overflow go to 0 immediately. No result_valid appears after release; a new start works.
